// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory request and fills the IF/ID register.
// It keeps a one-entry skid buffer for a response that arrives under stall, and drains a request that a redirect orphans.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic [6:0]  if_id_opcode
);

  // Handshake: once imem_req rises, imem_req and imem_addr stay fixed until the
  // cycle with imem_ready=1. That cycle completes the request. A request is never withdrawn.
  typedef enum logic [1:0] {BOOT, REQ, DRAIN, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ~32'h3;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;

    case (state_q)
      BOOT: begin
        state_d = REQ;
        if (redirect_valid) pc_d = redirect_tgt;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (!imem_ready) begin
            // The orphaned request still has to complete at its original address.
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (imem_ready) begin
          pc_d = pc_q + 32'd4;
          if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end else begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_rdata;
          end
        end else if (!stall) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_INSTR;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_d = redirect_tgt;
        if (imem_ready) state_d = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = REQ;
        end else if (!stall) begin
          if_id_valid_d = 1'b1;
          if_id_pc_d    = skid_pc_q;
          if_id_instr_d = skid_instr_q;
          state_d       = REQ;
        end
      end
      default: state_d = BOOT;
    endcase

    // A redirect squashes the IF/ID slot in every state and wins over stall.
    if (redirect_valid) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end

    imem_req_d  = (state_d == REQ) || (state_d == DRAIN);
    imem_addr_d = (state_d == DRAIN) ? drain_addr_d : pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      drain_addr_q  <= 32'h0;
      skid_instr_q  <= 32'h0;
      skid_pc_q     <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign if_id_valid  = if_id_valid_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc4    = if_id_pc_q + 32'd4;
  assign if_id_opcode = if_id_instr_q[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage.
// It applies directed vectors, a reset issued mid-drain, and a random phase checked against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] M   = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_opcode;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[19];

  // Model state: boot cycle, next fetch pc, orphaned request, skid entry, IF/ID.
  logic        m_boot;
  logic [31:0] m_pc;
  logic        m_stale;
  logic [31:0] m_stale_addr;
  logic [63:0] m_skid[$];
  logic        m_valid;
  logic [31:0] m_ifpc;
  logic [31:0] m_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr);
    logic [31:0] e_pc4;
    e_pc4 = e_pc + 32'd4;
    chk({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk({tag, " imem_addr"}, imem_addr, e_addr);
    chk({tag, " if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
    chk({tag, " if_id_pc"}, if_id_pc, e_pc);
    chk({tag, " if_id_instr"}, if_id_instr, e_instr);
    chk({tag, " if_id_pc4"}, if_id_pc4, e_pc4);
    chk({tag, " if_id_opcode"}, {25'b0, if_id_opcode}, {25'b0, e_instr[6:0]});
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_pc = 32'h0; m_stale = 1'b0; m_stale_addr = 32'h0;
    m_skid.delete();
    m_valid = 1'b0; m_ifpc = 32'h0; m_instr = NOP;
  endtask

  task automatic model_flush();
    m_valid = 1'b0;
    m_instr = NOP;
  endtask

  // Advance the model by one clock with the currently driven inputs.
  task automatic model_step();
    logic [31:0] tgt;
    logic [63:0] e;
    tgt = {redirect_pc[31:2], 2'b00};
    if (m_boot) begin
      m_boot = 1'b0;
      if (redirect_valid) begin m_pc = tgt; model_flush(); end
    end else if (m_skid.size() != 0) begin
      if (redirect_valid) begin
        m_skid.delete(); m_pc = tgt; model_flush();
      end else if (!stall) begin
        e = m_skid.pop_front();
        m_valid = 1'b1; m_instr = e[63:32]; m_ifpc = e[31:0];
      end
    end else if (m_stale) begin
      if (redirect_valid) begin m_pc = tgt; model_flush(); end
      if (imem_ready) m_stale = 1'b0;
    end else begin
      if (redirect_valid) begin
        model_flush();
        if (!imem_ready) begin m_stale = 1'b1; m_stale_addr = m_pc; end
        m_pc = tgt;
      end else if (imem_ready) begin
        if (stall) m_skid.push_back({imem_rdata, m_pc});
        else begin m_valid = 1'b1; m_ifpc = m_pc; m_instr = imem_rdata; end
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        model_flush();
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0,        1'b0, 32'h0,        NOP};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,          1'b1, M ^ 32'h0,      1'b1, 32'h0,        1'b0, 32'h0,        NOP};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,          1'b1, M ^ 32'h4,      1'b1, 32'h4,        1'b1, 32'h0,        M ^ 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,          1'b1, M ^ 32'h8,      1'b1, 32'h8,        1'b1, 32'h4,        M ^ 32'h4};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0,        1'b1, 32'h4,        M ^ 32'h4};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,          1'b1, M ^ 32'hC,      1'b1, 32'hC,        1'b1, 32'h8,        M ^ 32'h8};
    vecs[6]  = '{1'b0, 1'b1, 32'h103,        1'b0, 32'h0,          1'b1, 32'h10,       1'b1, 32'hC,        M ^ 32'hC};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h10,       1'b0, 32'hC,        NOP};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'hDEADBEEF,   1'b1, 32'h10,       1'b0, 32'hC,        NOP};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,          1'b1, M ^ 32'h100,    1'b1, 32'h100,      1'b0, 32'hC,        NOP};
    vecs[10] = '{1'b1, 1'b1, 32'h200,        1'b0, 32'h0,          1'b1, 32'h104,      1'b1, 32'h100,      M ^ 32'h100};
    vecs[11] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0BADF00D,   1'b1, 32'h104,      1'b0, 32'h100,      NOP};
    vecs[12] = '{1'b0, 1'b0, 32'h0,          1'b1, M ^ 32'h200,    1'b1, 32'h200,      1'b0, 32'h100,      NOP};
    vecs[13] = '{1'b0, 1'b1, 32'hFFFFFFFF,   1'b1, 32'hCAFEBABE,   1'b1, 32'h204,      1'b1, 32'h200,      M ^ 32'h200};
    vecs[14] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1234567F,   1'b1, 32'hFFFFFFFC, 1'b0, 32'h200,      NOP};
    vecs[15] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h0,        1'b1, 32'hFFFFFFFC, 32'h1234567F};
    vecs[16] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h55,         1'b1, 32'h0,        1'b0, 32'hFFFFFFFC, NOP};
    vecs[17] = '{1'b1, 1'b1, 32'h40,         1'b0, 32'h0,          1'b0, 32'h0,        1'b0, 32'hFFFFFFFC, NOP};
    vecs[18] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h40,       1'b0, 32'hFFFFFFFC, NOP};

    // Reset held
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
    chk("reset pc", dut.pc_q, 32'h0);

    // Directed vectors: boot, streaming, stall/skid, drain, redirect+stall, wrap
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 19; i++) begin
      stall = vecs[i].st; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      imem_ready = vecs[i].rdy; imem_rdata = vecs[i].rd;
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
      @(posedge clk);
      @(negedge clk);
    end

    // Enter DRAIN, then assert reset between clock edges
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; imem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("drain imem_req", {31'b0, imem_req}, 32'h1);
    chk("drain imem_addr", imem_addr, 32'h40);
    #1;
    rst = 1'b0;
    #1;
    chk("async rst imem_req", {31'b0, imem_req}, 32'h0);
    chk("async rst pc", dut.pc_q, 32'h0);
    chk("async rst if_id_valid", {31'b0, if_id_valid}, 32'h0);
    chk("async rst if_id_instr", if_id_instr, NOP);
    chk("async rst if_id_pc", if_id_pc, 32'h0);

    // Random phase against the model
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      imem_ready     = ($urandom_range(0, 2) != 0);
      imem_rdata     = $urandom;
      #1;
      check_outputs("rand", !m_boot && (m_skid.size() == 0),
                    m_stale ? m_stale_addr : m_pc, m_valid, m_ifpc, m_instr);
      model_step();
      @(posedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
